// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} in state END; EX stalls on start & ~ready.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        ZERO = 2'd1,
        ON   = 2'd2,
        END  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             load, clear, step;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             sign_q, sign_r;
    logic [CW-1:0]    counter;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign a_abs = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_abs = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Shift the next dividend bit into the partial remainder, then try a subtract.
    assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvsr};

    always_ff @(posedge clk) begin
        if (reset) state <= FREE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clear     = 1'b0;
        step      = 1'b0;
        case (state)
            FREE: begin
                if (start && !annul) begin
                    if (divisor == '0) begin
                        state_nxt = ZERO;
                        clear     = 1'b1;
                    end else begin
                        state_nxt = ON;
                        load      = 1'b1;
                    end
                end
            end
            ZERO: state_nxt = annul ? FREE : END;
            ON: begin
                if (annul) begin
                    state_nxt = FREE;
                end else begin
                    step = 1'b1;
                    if (counter == CNT_LAST) state_nxt = END;
                end
            end
            END: if (annul || !start) state_nxt = FREE;
            default: state_nxt = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            counter <= '0;
        end else if (load) begin
            rem     <= '0;
            quo     <= a_abs;
            dvsr    <= b_abs;
            sign_q  <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r  <= signed_div & dividend[WIDTH-1];
            counter <= '0;
        end else if (step) begin
            rem     <= trial[WIDTH] ? rem_sh : trial;
            quo     <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            counter <= counter + CW'(1);
        end
    end

    // Remainder takes the dividend's sign; the -2^(W-1)/-1 quotient simply wraps.
    assign q_fix = sign_q ? -quo : quo;
    assign r_fix = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_comb begin
        ready  = (state == END);
        result = ready ? {r_fix, q_fix} : '0;
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset, signed_div, start, annul;
    logic [W-1:0]   dividend, divisor;
    logic [2*W-1:0] result;
    logic           ready;

    int n_checks = 0;
    int n_errors = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // MIPS semantics: truncating division, remainder follows dividend, /0 gives 0.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide, scramble operands after acceptance, hold start `hold` extra cycles in END.
    task automatic do_div(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [63:0] exp;
        int cyc;
        exp = ref_div(s, a, b);
        signed_div = s;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        cyc        = 0;
        do begin
            tick();
            cyc++;
            if (cyc == 3) begin
                dividend   = $urandom;
                divisor    = $urandom;
                signed_div = ~s;
            end
        end while (!ready && cyc < 100);
        check({tag, " latency"}, 64'(cyc), (b == 32'd0) ? 64'd2 : 64'd33);
        check({tag, " result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold ready"}, 64'(ready), 64'd1);
            check({tag, " hold result"}, result, exp);
        end
        start = 1'b0;
        tick();
        check({tag, " drop ready"}, 64'(ready), 64'd0);
        check({tag, " drop result"}, result, 64'd0);
    endtask

    // Start a divide and annul it after `at` edges (33 lands in END).
    task automatic do_annul(input string tag, input int at);
        signed_div = 1'b0;
        dividend   = $urandom;
        divisor    = 32'd3;
        start      = 1'b1;
        repeat (at) tick();
        annul = 1'b1;
        tick();
        check({tag, " annul ready"}, 64'(ready), 64'd0);
        check({tag, " annul result"}, result, 64'd0);
        annul = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        check({tag, " idle ready"}, 64'(ready), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        signed_div = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (2) tick();
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);
        reset = 1'b0;
        tick();

        do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 0);
        do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        do_div("div 5/0", 1'b1, 32'd5, 32'd0, 0);
        do_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        do_annul("annul it10", 11);
        do_annul("annul last", 32);
        do_annul("annul end", 33);
        do_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        do_div("hold5", 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5);

        signed_div = 1'b1;
        dividend   = 32'd1000;
        divisor    = 32'd9;
        start      = 1'b1;
        repeat (21) tick();
        reset = 1'b1;
        start = 1'b0;
        tick();
        check("mid reset ready", 64'(ready), 64'd0);
        check("mid reset result", result, 64'd0);
        reset = 1'b0;
        tick();
        check("post reset ready", 64'(ready), 64'd0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            bit s;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            do_div($sformatf("rand%0d", n), s, a, b, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
